// File: rtl/key_fetch_ctrl.sv
// Reader-side key store controller: privileged fetch, single-consumer delivery, shadow zeroization, use-limit lockout.
// Optional DELIVER-state timeout is built when the KEY_TIMEOUT_EN macro is defined.
module key_fetch_ctrl #(
  parameter int unsigned KEY_W    = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_USES = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_priv,
  output logic             req_ready,
  output logic             store_rd_en,
  input  logic [KEY_W-1:0] store_key,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             err,
  output logic             locked
);

  localparam int unsigned LAT_W = 4;
  localparam int unsigned USE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DELIVER,
    ZERO
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_cnt_nxt;
  logic [USE_W-1:0] use_cnt;
  logic [USE_W-1:0] use_cnt_nxt;
  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] shadow_nxt;
  logic             err_nxt;

`ifdef KEY_TIMEOUT_EN
  localparam int unsigned TO_W = 8;

  logic [TO_W-1:0] to_cnt;

  // Counts stalled DELIVER cycles; held at zero in every other state so entry clears it.
  always_ff @(posedge clk) begin
    if (rst || state != DELIVER) begin
      to_cnt <= '0;
    end else if (!key_ready) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Next-state, counter and shadow update logic.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    use_cnt_nxt = use_cnt;
    shadow_nxt  = shadow;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_priv && !locked) begin
            state_nxt = ISSUE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      ISSUE: begin
        lat_cnt_nxt = LAT_W'(RD_LAT - 1);
        state_nxt   = WAIT;
      end

      WAIT: begin
        if (lat_cnt == '0) begin
          shadow_nxt = store_key;
          state_nxt  = DELIVER;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end

      DELIVER: begin
        // Shadow is wiped on the handshake edge so it is never live outside DELIVER.
        if (key_ready) begin
          shadow_nxt = '0;
          state_nxt  = ZERO;
          if (use_cnt != USE_W'(MAX_USES)) begin
            use_cnt_nxt = use_cnt + USE_W'(1);
          end
        end
`ifdef KEY_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          shadow_nxt = '0;
          state_nxt  = ZERO;
          err_nxt    = 1'b1;
        end
`endif
      end

      ZERO: begin
        shadow_nxt = '0;
        state_nxt  = IDLE;
      end

      default: begin
        shadow_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // State, shadow and registered outputs; key_out mirrors the shadow only in DELIVER.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      use_cnt     <= '0;
      shadow      <= '0;
      req_ready   <= 1'b0;
      store_rd_en <= 1'b0;
      key_valid   <= 1'b0;
      key_out     <= '0;
      err         <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_cnt_nxt;
      use_cnt     <= use_cnt_nxt;
      shadow      <= shadow_nxt;
      req_ready   <= (state_nxt == IDLE);
      store_rd_en <= (state_nxt == ISSUE);
      key_valid   <= (state_nxt == DELIVER);
      key_out     <= (state_nxt == DELIVER) ? shadow_nxt : '0;
      err         <= err_nxt;
      locked      <= (use_cnt == USE_W'(MAX_USES));
    end
  end

endmodule

// File: tb/tb_key_fetch_ctrl.sv
// Scoreboard bench for key_fetch_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share stimulus.
// Define KEY_TIMEOUT_EN to also exercise the DELIVER timeout (TIMEOUT=5).
`timescale 1ns/1ps
module tb_key_fetch_ctrl;

  localparam int unsigned KEY_W = 32;
`ifdef KEY_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 5;
  localparam int          HOLD    = 3;
`else
  localparam int unsigned TIMEOUT = 255;
  localparam int          HOLD    = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             req_valid;
  logic             req_priv;
  logic             key_ready;
  logic             sel3;
  logic [KEY_W-1:0] store_word;

  logic             req_ready1, rd_en1, key_valid1, err1, locked1;
  logic [KEY_W-1:0] sk1, key_out1;
  logic             req_ready3, rd_en3, key_valid3, err3, locked3;
  logic [KEY_W-1:0] sk3, key_out3;
  logic [1:0]       pipe3 = 2'b00;

  logic             o_req_ready, o_rd_en, o_key_valid;
  logic [KEY_W-1:0] o_key_out;

  int checks = 0;
  int errors = 0;
  logic [KEY_W-1:0] sb[$];

  key_fetch_ctrl #(.KEY_W(KEY_W), .RD_LAT(1), .MAX_USES(4), .TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_priv(req_priv),
    .req_ready(req_ready1), .store_rd_en(rd_en1), .store_key(sk1),
    .key_valid(key_valid1), .key_ready(key_ready), .key_out(key_out1),
    .err(err1), .locked(locked1)
  );

  key_fetch_ctrl #(.KEY_W(KEY_W), .RD_LAT(3), .MAX_USES(4), .TIMEOUT(TIMEOUT)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_priv(req_priv),
    .req_ready(req_ready3), .store_rd_en(rd_en3), .store_key(sk3),
    .key_valid(key_valid3), .key_ready(key_ready), .key_out(key_out3),
    .err(err3), .locked(locked3)
  );

  assign o_req_ready = sel3 ? req_ready3 : req_ready1;
  assign o_rd_en     = sel3 ? rd_en3     : rd_en1;
  assign o_key_valid = sel3 ? key_valid3 : key_valid1;
  assign o_key_out   = sel3 ? key_out3   : key_out1;

  // Key store model: data valid exactly RD_LAT cycles after the strobe, noise otherwise.
  always @(posedge clk) begin
    sk1   <= rd_en1 ? store_word : KEY_W'($urandom);
    pipe3 <= {pipe3[0], rd_en3};
    sk3   <= pipe3[1] ? store_word : KEY_W'($urandom);
  end

  // Shadow must be clear whenever no key is being presented.
  always @(negedge clk) begin
    if (rst === 1'b0 && key_valid1 === 1'b0) begin
      checks++;
      if (dut1.shadow !== '0) begin
        errors++;
        $display("FAIL shadow_zero got %h want 0 at %0t", dut1.shadow, $time);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    key_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic fetch(input logic [KEY_W-1:0] word, input int hold, input int lat);
    logic [KEY_W-1:0] exp;
    int   c;
    logic got;
    store_word = word;
    sb.push_back(word);
    req_valid = 1'b1;
    req_priv  = 1'b1;
    key_ready = (hold == 0);
    tick;
    req_valid = 1'b0;
    checks++;
    if (o_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL fetch_rd_en got %b want 1", o_rd_en);
    end
    got = 1'b0;
    c = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      tick;
      c = i;
      if (o_key_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        checks++;
        if (o_rd_en !== 1'b0 || o_key_out !== '0) begin
          errors++;
          $display("FAIL fetch_wait got rd=%b key=%h want rd=0 key=0", o_rd_en, o_key_out);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fetch_no_valid got no key_valid within 20 cycles want latency %0d", lat + 1);
      void'(sb.pop_front());
      key_ready = 1'b0;
      return;
    end
    if (c != lat + 1) begin
      errors++;
      $display("FAIL fetch_latency got %0d want %0d", c, lat + 1);
    end
    exp = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) tick;
      checks++;
      if (o_key_valid !== 1'b1 || o_key_out !== exp) begin
        errors++;
        $display("FAIL fetch_deliver cycle %0d got kv=%b key=%h want kv=1 key=%h", i, o_key_valid, o_key_out, exp);
      end
      if (i == hold) key_ready = 1'b1;
    end
    tick;
    key_ready = 1'b0;
    checks++;
    if (o_key_valid !== 1'b0 || o_key_out !== '0 || o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_zero got kv=%b key=%h rr=%b want 0 0 0", o_key_valid, o_key_out, o_req_ready);
    end
    tick;
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fetch_idle got rr=%b want 1", o_req_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    req_priv = 1'b0;
    key_ready = 1'b0;
    sel3 = 1'b0;
    store_word = '0;
    tick;
    tick;
    checks++;
    if (req_ready1 !== 1'b0 || rd_en1 !== 1'b0 || key_valid1 !== 1'b0 ||
        key_out1 !== '0 || err1 !== 1'b0 || locked1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rr=%b rd=%b kv=%b key=%h err=%b lk=%b want all 0",
               req_ready1, rd_en1, key_valid1, key_out1, err1, locked1);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (req_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got rr=%b want 1", req_ready1);
    end
  endtask

  task automatic test_basic;
    sel3 = 1'b0;
    fetch(32'hA5A5_1234, 0, 1);
  endtask

  task automatic test_denied;
    req_valid = 1'b1;
    req_priv = 1'b0;
    tick;
    req_valid = 1'b0;
    checks++;
    if (err1 !== 1'b1 || rd_en1 !== 1'b0 || req_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL denied_err got err=%b rd=%b rr=%b want 1 0 1", err1, rd_en1, req_ready1);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (err1 !== 1'b0 || rd_en1 !== 1'b0 || key_valid1 !== 1'b0 || key_out1 !== '0) begin
        errors++;
        $display("FAIL denied_quiet got err=%b rd=%b kv=%b key=%h want all 0", err1, rd_en1, key_valid1, key_out1);
      end
    end
  endtask

  task automatic test_hold;
    sel3 = 1'b0;
    fetch(32'hC3C3_0F0F, HOLD, 1);
  endtask

  task automatic test_lockout;
    logic [KEY_W-1:0] words [4];
    words[0] = 32'h1111_0001;
    words[1] = 32'h2222_0002;
    words[2] = 32'h3333_0003;
    words[3] = 32'h4444_0004;
    sel3 = 1'b0;
    do_reset;
    for (int k = 0; k < 4; k++) begin
      fetch(words[k], 0, 1);
      checks++;
      if (locked1 !== (k == 3)) begin
        errors++;
        $display("FAIL lockout_locked after fetch %0d got %b want %b", k + 1, locked1, (k == 3));
      end
    end
    req_valid = 1'b1;
    req_priv = 1'b1;
    tick;
    req_valid = 1'b0;
    checks++;
    if (err1 !== 1'b1 || rd_en1 !== 1'b0) begin
      errors++;
      $display("FAIL lockout_deny got err=%b rd=%b want err=1 rd=0", err1, rd_en1);
    end
    tick;
    checks++;
    if (err1 !== 1'b0 || rd_en1 !== 1'b0 || locked1 !== 1'b1 || req_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL lockout_after got err=%b rd=%b lk=%b rr=%b want 0 0 1 1", err1, rd_en1, locked1, req_ready1);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (locked1 !== 1'b0) begin
      errors++;
      $display("FAIL lockout_clear got lk=%b want 0", locked1);
    end
  endtask

  task automatic test_reset_wait;
    do_reset;
    sel3 = 1'b1;
    store_word = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    req_priv = 1'b1;
    key_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    checks++;
    if (rd_en3 !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_rd_en got %b want 1", rd_en3);
    end
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (key_valid3 !== 1'b0 || rd_en3 !== 1'b0 || req_ready3 !== 1'b0 || dut3.shadow !== '0) begin
      errors++;
      $display("FAIL rstwait_reset got kv=%b rd=%b rr=%b shadow=%h want 0 0 0 0",
               key_valid3, rd_en3, req_ready3, dut3.shadow);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (key_valid3 !== 1'b0 || key_out3 !== '0 || rd_en3 !== 1'b0 || dut3.shadow !== '0 || req_ready3 !== 1'b1) begin
        errors++;
        $display("FAIL rstwait_idle got kv=%b key=%h rd=%b shadow=%h rr=%b want 0 0 0 0 1",
                 key_valid3, key_out3, rd_en3, dut3.shadow, req_ready3);
      end
    end
    fetch(32'h0123_4567, 0, 3);
    sel3 = 1'b0;
  endtask

`ifdef KEY_TIMEOUT_EN
  task automatic test_timeout;
    logic got;
    sel3 = 1'b0;
    do_reset;
    store_word = 32'h5555_AAAA;
    req_valid = 1'b1;
    req_priv = 1'b1;
    key_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (key_valid1 === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout_no_valid got no key_valid within 20 cycles want 1");
      return;
    end
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      if (i > 0) tick;
      checks++;
      if (key_valid1 !== 1'b1 || key_out1 !== 32'h5555_AAAA || err1 !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold cycle %0d got kv=%b key=%h err=%b want 1 5555aaaa 0", i, key_valid1, key_out1, err1);
      end
    end
    tick;
    checks++;
    if (err1 !== 1'b1 || key_valid1 !== 1'b0 || key_out1 !== '0) begin
      errors++;
      $display("FAIL timeout_expire got err=%b kv=%b key=%h want 1 0 0", err1, key_valid1, key_out1);
    end
    tick;
    checks++;
    if (err1 !== 1'b0 || req_ready1 !== 1'b1 || dut1.use_cnt !== 8'd0) begin
      errors++;
      $display("FAIL timeout_after got err=%b rr=%b uses=%0d want 0 1 0", err1, req_ready1, dut1.use_cnt);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_denied;
    test_hold;
    test_lockout;
    test_reset_wait;
`ifdef KEY_TIMEOUT_EN
    test_timeout;
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000ns");
    $fatal(1);
  end

endmodule
